alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter DW, default 32, operand/result width; SHALL match the 32-bit ALU.
REQ-002 Parameter OPW, default 4, ALU opcode width.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid/req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready/req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-007 req0_op/req1_op  input  OPW  ALU opcode: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 SLL, 5 SLLV, 6 SRL, 7 SRLV, 8 ADDU, 9 SUBU, 10 ADD, 11 SUB, 12 SLT, 13 SLTU, 14 CLO, 15 CLZ.
REQ-008 req0_a/req0_b, req1_a/req1_b  input  DW  operands.
REQ-009 rsp_valid  output  1  response held.
REQ-010 rsp_ready  input  1  consumer takes response.
REQ-011 rsp_id  output  1  requester that owns the response.
REQ-012 rsp_result  output  DW  registered ALU result.
REQ-013 rsp_flags  output  4  registered flags, order {N,Z,C,V}.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP.
REQ-016 IDLE: if any reqN_valid, grant one requester; assert only its reqN_ready combinationally that cycle; latch op, a, b, id; go to EXEC.
REQ-017 Both valid in IDLE: grant the requester selected by the round-robin pointer; the pointer SHALL be 0 after reset.
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP and whenever reqN_valid is 0.
REQ-019 EXEC: the ALU SHALL be driven only from latched operands; the result and flags SHALL be registered at the end of the cycle; go to RESP.
REQ-020 RESP: rsp_valid=1; rsp_* SHALL stay stable until rsp_valid&&rsp_ready; on that handshake go to IDLE and set pointer to the requester other than rsp_id.
REQ-021 No bypass: a new request SHALL NOT be accepted in the same cycle as the response handshake; minimum spacing is 3 cycles per operation.
REQ-022 Latency: accept edge to rsp_valid high SHALL be exactly 2 cycles.
REQ-023 N SHALL equal result[31] and Z SHALL equal (result==0) for every opcode, computed locally.
REQ-024 C SHALL be taken from the ALU for opcodes 4-9 and forced to 0 otherwise.
REQ-025 V SHALL be taken from the ALU for opcodes 10-11 and forced to 0 otherwise.
REQ-026 A requester deasserting valid before ready SHALL be legal and SHALL cause no side effect.

Reset
REQ-027 rst in any state SHALL force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, pointer=0, busy=0 on the next edge.
REQ-028 reqN_ready SHALL be 0 during any cycle with rst=1.
REQ-029 An in-flight operation SHALL be discarded without a response.

Structure
REQ-030 Opcode constants (0-15), flag bit positions, and FSM state encodings SHALL live in the shared ALU package.
REQ-031 The block SHALL instantiate the existing ALU_32_bit as its only sub-module, with port order result, C, N, Z, V, opcode, a, b.

Verification
REQ-032 req0 ADD 7FFFFFFF+00000001 -> 2 cycles later rsp_valid=1, id=0, result=80000000, flags NZCV=1001.
REQ-033 Both valid after reset, req0 AND, req1 OR -> req0 served first (id 0), then req1 (id 1); the req1 accept comes no earlier than the cycle after the first response handshake.
REQ-034 SUBU 00000000-00000001 from req1 -> result=FFFFFFFF, NZCV=1010, id=1.
REQ-035 XOR FFFFFFFF^FFFFFFFF -> result=00000000, NZCV=0100.
REQ-036 rsp_ready held low 5 cycles in RESP -> rsp_* stable, both readies 0, busy=1; released -> IDLE next cycle.
REQ-037 rst pulsed during EXEC -> next cycle rsp_valid=0, busy=0, no response issued; a following simultaneous request grants req0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, arbiter FSM encoding.
package alu_share_arbiter_pkg;

   localparam int unsigned ALU_W  = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OP_W-1:0] OP_AND  = 4'd0;
   localparam logic [OP_W-1:0] OP_OR   = 4'd1;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
   localparam logic [OP_W-1:0] OP_NOR  = 4'd3;
   localparam logic [OP_W-1:0] OP_SLL  = 4'd4;
   localparam logic [OP_W-1:0] OP_SLLV = 4'd5;
   localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
   localparam logic [OP_W-1:0] OP_SRLV = 4'd7;
   localparam logic [OP_W-1:0] OP_ADDU = 4'd8;
   localparam logic [OP_W-1:0] OP_SUBU = 4'd9;
   localparam logic [OP_W-1:0] OP_ADD  = 4'd10;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd11;
   localparam logic [OP_W-1:0] OP_SLT  = 4'd12;
   localparam logic [OP_W-1:0] OP_SLTU = 4'd13;
   localparam logic [OP_W-1:0] OP_CLO  = 4'd14;
   localparam logic [OP_W-1:0] OP_CLZ  = 4'd15;

   // Flag vector order is {N,Z,C,V}.
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Number of consecutive bits equal to bitval starting at the MSB.
   function automatic logic [ALU_W-1:0] count_leading(input logic [ALU_W-1:0] v,
                                                      input logic bitval);
      logic [5:0] cnt;
      logic       done;
      cnt  = '0;
      done = 1'b0;
      for (int i = ALU_W - 1; i >= 0; i--) begin
         if (!done) begin
            if (v[i] == bitval) cnt = cnt + 6'd1;
            else                done = 1'b1;
         end
      end
      return ALU_W'(cnt);
   endfunction

endpackage

// File: rtl/ALU_32_bit.sv
// Combinational 32-bit ALU; shifts report the last bit shifted out on C,
// SUBU reports borrow on C, ADD/SUB report signed overflow on V.
module ALU_32_bit
   import alu_share_arbiter_pkg::*;
(
   output logic [ALU_W-1:0] result,
   output logic             C,
   output logic             N,
   output logic             Z,
   output logic             V,
   input  logic [OP_W-1:0]  opcode,
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b
);

   logic [ALU_W:0] wide;

   // Operation decode and arithmetic.
   always_comb begin
      result = '0;
      wide   = '0;
      C      = 1'b0;
      V      = 1'b0;
      case (opcode)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_SLL: begin
            wide   = {1'b0, a} << b[4:0];
            result = wide[ALU_W-1:0];
            C      = wide[ALU_W];
         end
         OP_SLLV: begin
            wide   = {1'b0, b} << a[4:0];
            result = wide[ALU_W-1:0];
            C      = wide[ALU_W];
         end
         OP_SRL: begin
            wide   = {a, 1'b0} >> b[4:0];
            result = wide[ALU_W:1];
            C      = wide[0];
         end
         OP_SRLV: begin
            wide   = {b, 1'b0} >> a[4:0];
            result = wide[ALU_W:1];
            C      = wide[0];
         end
         OP_ADDU, OP_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[ALU_W-1:0];
            C      = wide[ALU_W];
            V      = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
         end
         OP_SUBU, OP_SUB: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[ALU_W-1:0];
            C      = wide[ALU_W];
            V      = (a[ALU_W-1] != b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
         end
         OP_SLT:  result = {(ALU_W-1)'(0), ($signed(a) < $signed(b))};
         OP_SLTU: result = {(ALU_W-1)'(0), (a < b)};
         OP_CLO:  result = count_leading(a, 1'b1);
         OP_CLZ:  result = count_leading(a, 1'b0);
         default: result = '0;
      endcase
   end

   assign N = result[ALU_W-1];
   assign Z = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU; one operation in flight,
// IDLE -> EXEC -> RESP, response held until the consumer takes it.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned DW  = 32,
   parameter int unsigned OPW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OPW-1:0]    req0_op,
   input  logic [DW-1:0]     req0_a,
   input  logic [DW-1:0]     req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OPW-1:0]    req1_op,
   input  logic [DW-1:0]     req1_a,
   input  logic [DW-1:0]     req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DW-1:0]     rsp_result,
   output logic [FLAG_W-1:0] rsp_flags,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              accept, grant_id, load_rsp;
   logic [OPW-1:0]    op_q;
   logic [DW-1:0]     a_q, b_q;
   logic              id_q;
   logic [DW-1:0]     alu_result;
   logic              alu_c, alu_v;
   logic              unused_alu_n, unused_alu_z;
   logic [FLAG_W-1:0] flags_c;

   // ALU sees only the latched operands.
   ALU_32_bit u_alu (
      .result (alu_result),
      .C      (alu_c),
      .N      (unused_alu_n),
      .Z      (unused_alu_z),
      .V      (alu_v),
      .opcode (op_q),
      .a      (a_q),
      .b      (b_q)
   );

   // Flags: N/Z from the result, C/V only for the opcodes that define them.
   always_comb begin
      flags_c         = '0;
      flags_c[FLAG_N] = alu_result[DW-1];
      flags_c[FLAG_Z] = (alu_result == '0);
      case (op_q)
         OP_SLL, OP_SLLV, OP_SRL, OP_SRLV, OP_ADDU, OP_SUBU: flags_c[FLAG_C] = alu_c;
         OP_ADD, OP_SUB:                                     flags_c[FLAG_V] = alu_v;
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state, grant and combinational readies.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      load_rsp   = 1'b0;
      grant_id   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               if (req0_valid || req1_valid) begin
                  accept     = 1'b1;
                  req0_ready = !grant_id;
                  req1_ready = grant_id;
                  state_d    = S_EXEC;
               end
            end
            S_EXEC: begin
               load_rsp = 1'b1;
               state_d  = S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_d = S_IDLE;
                  ptr_d   = !rsp_id;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Operand latch, response registers, pointer and status.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         ptr_q      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         busy       <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= grant_id ? req1_op : req0_op;
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            id_q <= grant_id;
         end
         if (load_rsp) begin
            rsp_result <= alu_result;
            rsp_flags  <= flags_c;
            rsp_id     <= id_q;
         end
         ptr_q     <= ptr_d;
         rsp_valid <= (state_d == S_RESP);
         busy      <= (state_d != S_IDLE);
      end
   end

endmodule
